// File: rtl/led_pattern_gen_pkg.sv
// led_pkg: shared definitions for the LED pattern generator.
//   MODE_*       2-bit run-time mode encodings
//   dir_e        breathe ramp direction
//   unlit_level  LED drive level meaning "off" for the selected polarity
package led_pkg;

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic logic unlit_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: control/status bundle of the LED pattern generator.
//   en           run enable (0 freezes everything)
//   mode         pattern select
//   static_mask  pattern for STATIC mode
//   led          registered LED drive
//   step_pulse   one-cycle strobe per pattern step
// master = controller side, slave = generator side.
interface led_pattern_gen_if #(
    parameter int LED_NUM = 2
) ();
    logic               en;
    logic [1:0]         mode;
    logic [LED_NUM-1:0] static_mask;
    logic [LED_NUM-1:0] led;
    logic               step_pulse;

    modport master (
        output en, mode, static_mask,
        input  led, step_pulse
    );

    modport slave (
        input  en, mode, static_mask,
        output led, step_pulse
    );
endinterface

// File: rtl/led_pattern_gen_tick_gen.sv
// led_tick_gen: base-tick prescaler and pattern-step counter.
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   en                count enable
//   clr               restart both counters (takes priority over en)
//   tick              prescaler terminal count while enabled
//   step              tick on which the step counter is at its last value
module led_tick_gen #(
    parameter int TICK_DIV   = 50_000,
    parameter int STEP_TICKS = 1_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic step
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(STEP_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;

    always_comb begin
        // a restart swallows any tick/step landing in the same cycle
        tick       = en && !clr && (prescaler_q == PRE_LAST);
        step       = tick && (step_cnt_q == STEP_LAST);
        prescaler_d = prescaler_q;
        step_cnt_d  = step_cnt_q;
        if (clr) begin
            prescaler_d = '0;
            step_cnt_d  = '0;
        end else if (en) begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
            if (tick) begin
                step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prescaler_q <= '0;
            step_cnt_q  <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            step_cnt_q  <= step_cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: drives LED_NUM LEDs with STATIC, BLINK, CHASE or BREATHE
// patterns.
//   sys_clk, sys_rst  clock, synchronous active-high reset
//   bus (slave)       en, mode, static_mask in; led, step_pulse out
//
// Breathe direction FSM:
//   state    | meaning
//   DIR_UP   | duty increments on each step; flips at duty max
//   DIR_DOWN | duty decrements on each step; flips at duty 0
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int LED_NUM        = 2,
    parameter int TICK_DIV       = 50_000,
    parameter int STEP_TICKS     = 1_000,
    parameter int PWM_BITS       = 8,
    parameter int LED_ACTIVE_LOW = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    led_pattern_gen_if.slave bus
);

    localparam logic [LED_NUM-1:0]  UNLIT_VEC  = {LED_NUM{unlit_level(LED_ACTIVE_LOW)}};
    localparam logic [LED_NUM-1:0]  ONEHOT_RST = LED_NUM'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
    localparam logic [PWM_BITS-1:0] DUTY_TURN  = DUTY_MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] DUTY_ONE   = PWM_BITS'(1);

    logic [1:0]          mode_q, mode_d;
    logic                phase_q, phase_d;
    logic [LED_NUM-1:0]  onehot_q, onehot_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    dir_e                dir_q, dir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [LED_NUM-1:0]  led_q, led_d;
    logic                step_pulse_q, step_pulse_d;

    logic               mode_chg;
    logic               tick;
    logic               step;
    logic [LED_NUM-1:0] lit;

    assign mode_chg = (bus.mode != mode_q);

    led_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .STEP_TICKS (STEP_TICKS)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (bus.en),
        .clr     (mode_chg),
        .tick    (tick),
        .step    (step)
    );

    always_comb begin
        lit = '0;
        case (mode_q)
            MODE_STATIC:  lit = bus.static_mask;
            MODE_BLINK:   lit = {LED_NUM{phase_q}};
            MODE_CHASE:   lit = onehot_q;
            MODE_BREATHE: lit = {LED_NUM{pwm_cnt_q < duty_q}};
            default:      lit = '0;
        endcase
    end

    always_comb begin
        mode_d       = bus.mode;
        phase_d      = phase_q;
        onehot_d     = onehot_q;
        duty_d       = duty_q;
        dir_d        = dir_q;
        pwm_cnt_d    = pwm_cnt_q;
        led_d        = led_q;
        step_pulse_d = step;

        if (bus.en) begin
            led_d     = lit ^ UNLIT_VEC;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end

        if (mode_chg) begin
            phase_d   = 1'b0;
            onehot_d  = ONEHOT_RST;
            duty_d    = '0;
            dir_d     = DIR_UP;
            pwm_cnt_d = '0;
        end else if (step) begin
            phase_d  = ~phase_q;
            // rotate left; with a single LED this degenerates to a hold
            onehot_d = (onehot_q << 1) | (onehot_q >> (LED_NUM - 1));
            if (dir_q == DIR_UP) begin
                duty_d = duty_q + 1'b1;
                if (duty_q == DUTY_TURN) dir_d = DIR_DOWN;
            end else begin
                duty_d = duty_q - 1'b1;
                if (duty_q == DUTY_ONE) dir_d = DIR_UP;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q       <= MODE_STATIC;
            phase_q      <= 1'b0;
            onehot_q     <= ONEHOT_RST;
            duty_q       <= '0;
            dir_q        <= DIR_UP;
            pwm_cnt_q    <= '0;
            led_q        <= UNLIT_VEC;
            step_pulse_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            phase_q      <= phase_d;
            onehot_q     <= onehot_d;
            duty_q       <= duty_d;
            dir_q        <= dir_d;
            pwm_cnt_q    <= pwm_cnt_d;
            led_q        <= led_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (active-high and active-low LEDs)
// share stimulus; a counting reference model predicts led and step_pulse.
module tb_led_pattern_gen;

    localparam int LN     = 4;
    localparam int TD     = 4;
    localparam int ST     = 2;
    localparam int PB     = 3;
    localparam int PERIOD = TD * ST;
    localparam int DMAX   = (1 << PB) - 1;
    localparam int PWMP   = 1 << PB;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic en;
    logic [1:0] mode;
    logic [LN-1:0] mask;

    int total = 0;
    int bad   = 0;

    // model state: enabled cycles since the last pattern restart
    int            m_cnt;
    logic [1:0]    m_mode_q;
    logic [LN-1:0] m_led;
    logic          m_sp;

    led_pattern_gen_if #(.LED_NUM(LN)) if0 ();
    led_pattern_gen_if #(.LED_NUM(LN)) if1 ();

    assign if0.en = en;
    assign if0.mode = mode;
    assign if0.static_mask = mask;
    assign if1.en = en;
    assign if1.mode = mode;
    assign if1.static_mask = mask;

    led_pattern_gen #(.LED_NUM(LN), .TICK_DIV(TD), .STEP_TICKS(ST), .PWM_BITS(PB),
                      .LED_ACTIVE_LOW(0)) dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if0));
    led_pattern_gen #(.LED_NUM(LN), .TICK_DIV(TD), .STEP_TICKS(ST), .PWM_BITS(PB),
                      .LED_ACTIVE_LOW(1)) dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if1));

    always #5 sys_clk = ~sys_clk;

    // lit pattern after n enabled cycles in mode md
    function automatic logic [LN-1:0] model_lit(input logic [1:0] md, input int n,
                                                input logic [LN-1:0] msk);
        int k;
        int m;
        int d;
        logic [LN-1:0] one;
        k = n / PERIOD;
        one = 1;
        case (md)
            2'd0: return msk;
            2'd1: return (k % 2 == 1) ? '1 : '0;
            2'd2: return one << (k % LN);
            default: begin
                m = k % (2 * DMAX);
                d = (m <= DMAX) ? m : 2 * DMAX - m;
                return ((n % PWMP) < d) ? '1 : '0;
            end
        endcase
    endfunction

    // one clock: model follows the edge, then move to the sampling point
    task automatic advance();
        logic [LN-1:0] lit;
        @(posedge sys_clk);
        if (sys_rst) begin
            m_cnt = 0;
            m_mode_q = 2'd0;
            m_led = '0;
            m_sp = 1'b0;
        end else begin
            lit = model_lit(m_mode_q, m_cnt, mask);
            if (en) m_led = lit;
            m_sp = en && (mode == m_mode_q) && (m_cnt % PERIOD == PERIOD - 1);
            if (mode != m_mode_q) m_cnt = 0;
            else if (en) m_cnt = m_cnt + 1;
            m_mode_q = mode;
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; en = 1'b1; mode = 2'd1; mask = '0;
        for (int i = 0; i < 5; i++) begin
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {4'b0000, 4'b1111, 2'b00}) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b/%b/%b%b exp=0000/1111/00",
                         i, if0.led, if1.led, if0.step_pulse, if1.step_pulse);
            end
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL reset_release cyc=%0d got=%b/%b/%b%b exp=%b/%b/%b",
                         i, if0.led, if1.led, if0.step_pulse, if1.step_pulse, m_led, ~m_led, m_sp);
            end
        end
    endtask

    task automatic test_blink();
        int lit_seen;
        lit_seen = 0;
        mode = 2'd1; en = 1'b1;
        for (int i = 0; i < 48; i++) begin
            advance();
            if (if0.led === 4'b1111) lit_seen++;
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL blink cyc=%0d got=%b/%b/%b exp=%b/%b", i, if0.led, if1.led,
                         if0.step_pulse, m_led, m_sp);
            end
        end
        total++;
        if (lit_seen !== 24) begin
            bad++;
            $display("FAIL blink_duty got=%0d exp=24", lit_seen);
        end
    endtask

    task automatic test_chase();
        mode = 2'd2; en = 1'b1;
        for (int i = 0; i < 44; i++) begin
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL chase cyc=%0d got=%b/%b/%b exp=%b/%b", i, if0.led, if1.led,
                         if0.step_pulse, m_led, m_sp);
            end
        end
        mode = 2'd0; mask = 4'b1010;
        for (int i = 0; i < 6; i++) begin
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL chase_static cyc=%0d got=%b/%b exp=%b", i, if0.led, if1.led, m_led);
            end
        end
        total++;
        if (if0.led !== 4'b1010 || if1.led !== 4'b0101) begin
            bad++;
            $display("FAIL static_polarity got=%b/%b exp=1010/0101", if0.led, if1.led);
        end
        mode = 2'd2;
        advance();
        advance();
        total++;
        if (if0.led !== 4'b0001) begin
            bad++;
            $display("FAIL chase_restart got=%b exp=0001", if0.led);
        end
        for (int i = 0; i < 20; i++) begin
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL chase_after cyc=%0d got=%b exp=%b", i, if0.led, m_led);
            end
        end
    endtask

    task automatic test_en_freeze();
        int guard;
        guard = 0;
        mode = 2'd2; en = 1'b1;
        while (if0.led !== 4'b0100 && guard < 64) begin
            advance();
            guard++;
        end
        total++;
        if (guard >= 64) begin
            bad++;
            $display("FAIL freeze_reach got=%b exp=0100", if0.led);
        end
        advance();
        advance();
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            advance();
            total++;
            if (if0.led !== 4'b0100 || if0.step_pulse !== 1'b0 ||
                {if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL freeze_hold cyc=%0d got=%b/%b exp=0100/0", i, if0.led, if0.step_pulse);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL freeze_resume cyc=%0d got=%b/%b exp=%b/%b", i, if0.led,
                         if0.step_pulse, m_led, m_sp);
            end
        end
    endtask

    task automatic test_breathe();
        int lit_cnt;
        int maxw;
        mode = 2'd3; en = 1'b1;
        maxw = 0;
        lit_cnt = 0;
        for (int i = 0; i < 2 * DMAX * PERIOD + 24; i++) begin
            advance();
            if (if0.led === 4'b1111) lit_cnt++;
            if (i % PWMP == PWMP - 1) begin
                if (lit_cnt > maxw) maxw = lit_cnt;
                lit_cnt = 0;
            end
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL breathe cyc=%0d got=%b/%b/%b exp=%b/%b", i, if0.led, if1.led,
                         if0.step_pulse, m_led, m_sp);
            end
        end
        total++;
        if (maxw !== DMAX) begin
            bad++;
            $display("FAIL breathe_peak got=%0d exp=%0d", maxw, DMAX);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) en = ~en;
            if ($urandom_range(0, 3) == 0) mask = 4'($urandom);
            sys_rst = ($urandom_range(0, 99) == 0);
            advance();
            total++;
            if ({if0.led, if1.led, if0.step_pulse, if1.step_pulse} !== {m_led, ~m_led, m_sp, m_sp}) begin
                bad++;
                $display("FAIL random cyc=%0d mode=%0d en=%b got=%b/%b/%b exp=%b/%b", i, mode, en,
                         if0.led, if1.led, if0.step_pulse, m_led, m_sp);
            end
        end
        sys_rst = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1; en = 1'b1; mode = 2'd1; mask = '0;
        m_cnt = 0; m_mode_q = 2'd0; m_led = '0; m_sp = 1'b0;
        @(negedge sys_clk);
        test_reset();
        test_blink();
        test_chase();
        test_en_freeze();
        test_breathe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised successor to the two-LED twinkle driver: drives LED_NUM LEDs from one clock with four run-time selectable modes (static, blink, chase, breathe/PWM).
- Sits at board top between the clock/reset generator and the LED pins.
- The prescaler and step timing are generic, so the same block serves simulation (small dividers) and hardware (large dividers).

Parameters:
- LED_NUM, 2: number of LED outputs (≥1).
- TICK_DIV, 50_000: sys_clk cycles per base tick (≥2).
- STEP_TICKS, 1_000: ticks per pattern step (≥1).
- PWM_BITS, 8: PWM counter/duty width (≥2).
- LED_ACTIVE_LOW, 0: 1 inverts every LED output bit.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- en  in  1  1 = run; 0 = freeze all counters and hold led.
- mode  in  2  0 STATIC, 1 BLINK, 2 CHASE, 3 BREATHE.
- static_mask  in  LED_NUM  pattern shown in STATIC (1 = lit).
- led  out  LED_NUM  registered LED drive, polarity per LED_ACTIVE_LOW.
- step_pulse  out  1  one-cycle strobe on every pattern step.

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, sampled on the sys_clk rising edge.
- Reset values: prescaler=0, step_cnt=0, phase=0, onehot=1 (bit0), duty=0, dir=up, pwm_cnt=0, mode_q=0, step_pulse=0. led = all-unlit (0, or all ones when LED_ACTIVE_LOW=1).
- Tick: prescaler counts 0..TICK_DIV-1 while en=1 and wraps. tick=1 when prescaler==TICK_DIV-1 and en=1.
- Step: step_cnt advances on tick over 0..STEP_TICKS-1 and wraps. Internal step=1 on the tick where step_cnt==STEP_TICKS-1. step_pulse is step registered, i.e. one cycle late.
- Period: one step every TICK_DIV*STEP_TICKS enabled cycles.
- pwm_cnt: free-runs 0..2^PWM_BITS-1 every enabled cycle and wraps.
- STATIC: lit = static_mask.
- BLINK: phase toggles on step; lit = {LED_NUM{phase}}. First step lights all LEDs.
- CHASE: onehot rotates left on step, MSB wraps to bit0; lit = onehot. With LED_NUM=1 the LED stays lit.
- BREATHE:
  - On step, duty moves ±1 per dir.
  - When duty reaches 2^PWM_BITS-1, dir flips to down in the same update. When it reaches 0, dir flips to up.
  - The sequence is 0,1,…,max,max-1,…,0,1,…, with no repeated endpoints.
  - lit = {LED_NUM{pwm_cnt < duty}}: duty=0 is fully off, duty=max is lit max/2^PWM_BITS of the time.
- Output register: led <= lit XOR {LED_NUM{LED_ACTIVE_LOW}}. There is 1 cycle of latency from internal state to led.
- Mode change: mode_q registers mode. In any cycle where mode != mode_q, all pattern state (prescaler, step_cnt, phase, onehot, duty, dir, pwm_cnt) returns to its reset value. The new mode's first output appears on the following cycle.
- Mode change vs. step: a mode change overrides a step occurring in the same cycle.
- en=0: all state and led hold their values; step_pulse=0.
- Mode change while en=0: the state restart still occurs.
- Reset mid-operation: returns to reset values on the next edge regardless of en or mode.
- static_mask: takes effect 1 cycle after it changes; the step counters are not disturbed.

Decomposition:
- Shared package led_pkg holds:
  - the mode encodings MODE_STATIC/BLINK/CHASE/BREATHE (2-bit localparams);
  - the function that computes the all-unlit constant from LED_ACTIVE_LOW.
- One sub-module, led_tick_gen (params TICK_DIV, STEP_TICKS; ports sys_clk, sys_rst, en, clr, tick, step), owns the prescaler and step counter. Its clr input is driven by the mode-change detect.
- Expected size is about 150–250 lines total.

Test Plan (sim params: LED_NUM=4, TICK_DIV=4, STEP_TICKS=2, PWM_BITS=3, LED_ACTIVE_LOW=0):
- Reset: hold sys_rst=1 for 5 cycles with mode=1, en=1 -> led=4'b0000 and step_pulse=0 throughout. After release, the first step_pulse occurs at cycle 8 and recurs every 8 cycles.
- BLINK: mode=1, en=1 -> led alternates 1111 / 0000, each level lasting 8 cycles, first 1111 right after the first step.
- CHASE: mode=2 -> led sequence 0001,0010,0100,1000,0001, each held 8 cycles. After a mid-run switch to mode=0 with static_mask=1010 and back to mode=2, the pattern restarts at 0001.
- BREATHE: mode=3 -> over successive 8-cycle PWM periods, the lit-cycle count per period follows duty 0,1,…,7,6,…,0,1. Duty=0 gives 0 lit cycles; duty=7 gives 7.
- en freeze: set en=0 for 20 cycles mid-CHASE at led=0100 -> led holds 0100 and no step_pulse. After en=1, led advances to 1000 after the remaining prescaler/step count, not from zero.
- Polarity: LED_ACTIVE_LOW=1, mode=0, static_mask=0011 -> led=1100; during reset led=1111.
